// File: rtl/syn_fifo.sv
// Single-clock parametrised FIFO with fill count, almost-full/empty thresholds,
// sticky overflow/underflow flags and a standard or first-word-fall-through read port.
module syn_fifo #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 4,
    parameter int DATA_DEPTH    = 1 << ADDR_WIDTH,
    parameter bit FWFT          = 1'b0,
    parameter int AFULL_THRESH  = 12,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  wr_en,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    if (ADDR_WIDTH < 1) begin : g_bad_addr
        $fatal(1, "syn_fifo: ADDR_WIDTH must be at least 1");
    end
    if (DATA_DEPTH != (1 << ADDR_WIDTH)) begin : g_bad_depth
        $fatal(1, "syn_fifo: DATA_DEPTH is derived from ADDR_WIDTH and must not be overridden");
    end
    if (AFULL_THRESH < 1 || AFULL_THRESH > DATA_DEPTH) begin : g_bad_afull
        $fatal(1, "syn_fifo: AFULL_THRESH out of range 1..DATA_DEPTH");
    end
    if (AEMPTY_THRESH < 0 || AEMPTY_THRESH > DATA_DEPTH - 1) begin : g_bad_aempty
        $fatal(1, "syn_fifo: AEMPTY_THRESH out of range 0..DATA_DEPTH-1");
    end

    localparam logic [ADDR_WIDTH:0] AFULL_L  = AFULL_THRESH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AEMPTY_L = AEMPTY_THRESH[ADDR_WIDTH:0];

    logic [DATA_WIDTH-1:0] mem_q [DATA_DEPTH];

    logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;
    logic [ADDR_WIDTH-1:0] wr_addr, rd_addr;
    logic                  wr_acc, rd_acc;

    // Status is decoded purely from the pointer registers; wr_en/rd_en never reach it.
    assign wr_addr      = wr_ptr_q[ADDR_WIDTH-1:0];
    assign rd_addr      = rd_ptr_q[ADDR_WIDTH-1:0];
    assign empty        = (wr_ptr_q == rd_ptr_q);
    assign full         = (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]) &&
                          (wr_addr == rd_addr);
    assign count        = wr_ptr_q - rd_ptr_q;
    assign almost_full  = (count >= AFULL_L);
    assign almost_empty = (count <= AEMPTY_L);
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

    // Reset outranks any access presented in the same cycle.
    assign wr_acc = wr_en && !full  && !rst;
    assign rd_acc = rd_en && !empty && !rst;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (wr_en && full) begin
            ovf_d = 1'b1;
        end
        if (rd_en && empty) begin
            unf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wr_addr] <= data_in;
        end
    end

    if (FWFT) begin : g_fwft
        // Head word is presented continuously; rd_en only acknowledges it.
        assign data_out = mem_q[rd_addr];
    end else begin : g_std
        logic [DATA_WIDTH-1:0] dout_q, dout_d;

        always_comb begin
            dout_d = dout_q;
            if (rd_acc) begin
                dout_d = mem_q[rd_addr];
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                dout_q <= '0;
            end else begin
                dout_q <= dout_d;
            end
        end

        assign data_out = dout_q;
    end

endmodule
